// File: rtl/mm_port_arb_pkg.sv
// Shared types and default widths for the operand-memory port-0 arbiter.
package mm_port_arb_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;
  localparam int LW_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Requester index: 0 = host operand loader, 1 = modexp engine.
  typedef logic owner_t;

  localparam owner_t OWNER_0 = 1'b0;
  localparam owner_t OWNER_1 = 1'b1;

endpackage

// File: rtl/mm_port_arb_pick.sv
// Winner selection for the two requesters plus the last-grant history.
// MM_PORT_ARB_RR_EN defined: round-robin on ties (the requester not granted
// last wins). Undefined: fixed priority, requester 0 wins every tie.
module mm_port_arb_pick
  import mm_port_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req_0,
  input  logic   req_1,
  input  logic   take,
  output owner_t grant
);

  owner_t last_grant;

  // Remember who won the most recent accepted burst; reset favours requester 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= OWNER_1;
    end else if (take) begin
      last_grant <= grant;
    end
  end

  // With no request the grant is a don't-care (take is low), so it simply
  // repeats the history value.
`ifdef MM_PORT_ARB_RR_EN
  always_comb begin
    grant = last_grant;
    if (req_0 && req_1) begin
      grant = (last_grant == OWNER_1) ? OWNER_0 : OWNER_1;
    end else if (req_0) begin
      grant = OWNER_0;
    end else if (req_1) begin
      grant = OWNER_1;
    end
  end
`else
  always_comb begin
    grant = last_grant;
    if (req_0) begin
      grant = OWNER_0;
    end else if (req_1) begin
      grant = OWNER_1;
    end
  end
`endif

endmodule

// File: rtl/mm_port_arb.sv
// Arbiter and burst sequencer for port 0 of the 256x16 Montgomery operand
// memory. Optional round-robin tie-breaking via MM_PORT_ARB_RR_EN (handled in
// mm_port_arb_pick).
//
// state | meaning
// IDLE  | no burst; requests sampled, winner latched on the next edge
// BUSY  | one beat per cycle until the beat counter reaches zero
module mm_port_arb
  import mm_port_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_0,
  input  logic          req_1,
  input  logic          we_0,
  input  logic          we_1,
  input  logic [AW-1:0] addr_0,
  input  logic [AW-1:0] addr_1,
  input  logic [LW-1:0] len_0,
  input  logic [LW-1:0] len_1,
  input  logic [DW-1:0] wdata_0,
  input  logic [DW-1:0] wdata_1,
  output logic          ack_0,
  output logic          ack_1,
  output logic          wbeat_0,
  output logic          wbeat_1,
  output logic [DW-1:0] rdata_0,
  output logic [DW-1:0] rdata_1,
  output logic          rvalid_0,
  output logic          rvalid_1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout
);

  state_t        state;
  state_t        state_nx;
  owner_t        owner;
  owner_t        grant;
  logic          we_q;
  logic [LW-1:0] rem;
  logic          take;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [LW-1:0] win_len;
  logic [DW-1:0] rhold_0;
  logic [DW-1:0] rhold_1;

  assign take = (state == IDLE) && (req_0 || req_1);

  mm_port_arb_pick u_pick (
    .clk   (clk),
    .rst_n (rst_n),
    .req_0 (req_0),
    .req_1 (req_1),
    .take  (take),
    .grant (grant)
  );

  assign win_we   = (grant == OWNER_1) ? we_1   : we_0;
  assign win_addr = (grant == OWNER_1) ? addr_1 : addr_0;
  assign win_len  = (grant == OWNER_1) ? len_1  : len_0;

  assign mem_din = (owner == OWNER_1) ? wdata_1 : wdata_0;

  // Memory read data is itself registered one cycle after the address, so it
  // is passed straight through while valid and held otherwise.
  assign rdata_0 = rvalid_0 ? mem_dout : rhold_0;
  assign rdata_1 = rvalid_1 ? mem_dout : rhold_1;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state: leave IDLE on an accepted request, return when the last beat issues.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (take) state_nx = BUSY;
      BUSY:    if (rem == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Burst datapath: latch the winner, step address/beat counter, register
  // the per-requester strobes and capture returned read words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner    <= OWNER_0;
      we_q     <= 1'b0;
      rem      <= '0;
      mem_addr <= '0;
      mem_we   <= 1'b0;
      ack_0    <= 1'b0;
      ack_1    <= 1'b0;
      wbeat_0  <= 1'b0;
      wbeat_1  <= 1'b0;
      rvalid_0 <= 1'b0;
      rvalid_1 <= 1'b0;
      rhold_0  <= '0;
      rhold_1  <= '0;
    end else begin
      ack_0    <= 1'b0;
      ack_1    <= 1'b0;
      wbeat_0  <= 1'b0;
      wbeat_1  <= 1'b0;
      mem_we   <= 1'b0;
      rvalid_0 <= (state == BUSY) && !we_q && (owner == OWNER_0);
      rvalid_1 <= (state == BUSY) && !we_q && (owner == OWNER_1);
      if (rvalid_0) rhold_0 <= mem_dout;
      if (rvalid_1) rhold_1 <= mem_dout;
      if (take) begin
        owner    <= grant;
        we_q     <= win_we;
        rem      <= win_len;
        mem_addr <= win_addr;
        mem_we   <= win_we;
        ack_0    <= (grant == OWNER_0);
        ack_1    <= (grant == OWNER_1);
        wbeat_0  <= (grant == OWNER_0) && win_we;
        wbeat_1  <= (grant == OWNER_1) && win_we;
      end else if ((state == BUSY) && (rem != '0)) begin
        rem      <= rem - 1'b1;
        mem_addr <= mem_addr + 1'b1;
        mem_we   <= we_q;
        wbeat_0  <= (owner == OWNER_0) && we_q;
        wbeat_1  <= (owner == OWNER_1) && we_q;
      end
    end
  end

endmodule

// File: tb/tb_mm_port_arb.sv
// Self-checking bench for mm_port_arb with a behavioural 256x16 memory.
module tb_mm_port_arb;
  import mm_port_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_0, req_1, we_0, we_1;
  logic [7:0]  addr_0, addr_1;
  logic [3:0]  len_0, len_1;
  logic [15:0] wdata_0, wdata_1;
  logic        ack_0, ack_1, wbeat_0, wbeat_1, rvalid_0, rvalid_1;
  logic [15:0] rdata_0, rdata_1;
  logic [7:0]  mem_addr;
  logic [15:0] mem_din, mem_dout;
  logic        mem_we;

  logic [15:0] mem [0:255];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [23:0] wq[$];
  logic [15:0] rq0[$];
  logic [15:0] rq1[$];

  mm_port_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
    .addr_0(addr_0), .addr_1(addr_1), .len_0(len_0), .len_1(len_1),
    .wdata_0(wdata_0), .wdata_1(wdata_1),
    .ack_0(ack_0), .ack_1(ack_1), .wbeat_0(wbeat_0), .wbeat_1(wbeat_1),
    .rdata_0(rdata_0), .rdata_1(rdata_1), .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: write on mem_we, registered read of the presented address.
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  // Scoreboard: every write beat and every returned read word is popped here.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      total++;
      if (wq.size() == 0) begin
        bad++;
        $display("FAIL write_unexpected: addr=%h data=%h, none expected", mem_addr, mem_din);
      end else begin
        logic [23:0] e;
        e = wq.pop_front();
        if ({mem_addr, mem_din} !== e) begin
          bad++;
          $display("FAIL write_beat: got addr=%h data=%h, want addr=%h data=%h",
                   mem_addr, mem_din, e[23:16], e[15:0]);
        end
      end
    end
    if (rvalid_0 === 1'b1) begin
      total++;
      if (rq0.size() == 0) begin
        bad++;
        $display("FAIL rdata_0_unexpected: got %h", rdata_0);
      end else begin
        logic [15:0] e0;
        e0 = rq0.pop_front();
        if (rdata_0 !== e0) begin
          bad++;
          $display("FAIL rdata_0: got %h want %h", rdata_0, e0);
        end
      end
    end
    if (rvalid_1 === 1'b1) begin
      total++;
      if (rq1.size() == 0) begin
        bad++;
        $display("FAIL rdata_1_unexpected: got %h", rdata_1);
      end else begin
        logic [15:0] e1;
        e1 = rq1.pop_front();
        if (rdata_1 !== e1) begin
          bad++;
          $display("FAIL rdata_1: got %h want %h", rdata_1, e1);
        end
      end
    end
  end

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [70:0] outs;
    int act;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    outs = {ack_0, ack_1, wbeat_0, wbeat_1, rvalid_0, rvalid_1, mem_we, mem_addr, rdata_0, rdata_1, 16'h0};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
    total++;
    if (mem_we !== 1'b0) begin
      bad++;
      $display("FAIL reset_mem_we: got %b want 0", mem_we);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    act = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack_0 || ack_1 || wbeat_0 || wbeat_1 || rvalid_0 || rvalid_1 || mem_we) act++;
    end
    total++;
    if (act != 0 || dut.state !== IDLE) begin
      bad++;
      $display("FAIL reset_idle: active cycles=%0d state=%0d want 0 and IDLE", act, dut.state);
    end
  endtask

  task automatic test_write_wrap();
    logic [15:0] words [4];
    int idx, acks, wb, other;
    logic saw_ack, saw_wb;
    logic [7:0] a;
    for (int i = 0; i < 4; i++) begin
      words[i] = 16'h00A0 + 16'(i);
      a = 8'hFE + 8'(i);
      wq.push_back({a, words[i]});
    end
    @(posedge clk);
    #1;
    req_0 = 1'b1; we_0 = 1'b1; addr_0 = 8'hFE; len_0 = 4'd3; wdata_0 = words[0];
    idx = 0; acks = 0; wb = 0; other = 0;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      @(negedge clk);
      saw_ack = ack_0;
      saw_wb  = wbeat_0;
      if (ack_0) acks++;
      if (wbeat_0) wb++;
      if (ack_1 || wbeat_1 || rvalid_1 || rvalid_0) other++;
      @(posedge clk);
      #1;
      if (saw_ack) req_0 = 1'b0;
      if (saw_wb) begin
        idx++;
        if (idx < 4) wdata_0 = words[idx];
      end
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (acks != 1) begin bad++; $display("FAIL wrap_ack_count: got %0d want 1", acks); end
    total++;
    if (wb != 4) begin bad++; $display("FAIL wrap_wbeat_count: got %0d want 4", wb); end
    total++;
    if (other != 0) begin bad++; $display("FAIL wrap_non_owner: got %0d strobes want 0", other); end
    total++;
    if (wq.size() != 0) begin bad++; $display("FAIL wrap_pending: got %0d left want 0", wq.size()); end
    total++;
    if (mem[8'h00] !== 16'h00A2 || mem[8'h01] !== 16'h00A3) begin
      bad++;
      $display("FAIL wrap_mem: got %h %h want 00a2 00a3", mem[8'h00], mem[8'h01]);
    end
  endtask

  task automatic test_single_read();
    int c0, ack_c, rv_c, rv_n, other;
    logic saw_ack;
    preload(8'h10, 16'h1234);
    @(posedge clk);
    #1;
    req_1 = 1'b1; we_1 = 1'b0; addr_1 = 8'h10; len_1 = 4'd0;
    c0 = cyc;
    rq1.push_back(16'h1234);
    ack_c = -1; rv_c = -1; rv_n = 0; other = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      saw_ack = ack_1;
      if (ack_1) ack_c = cyc;
      if (rvalid_1) begin rv_n++; rv_c = cyc; end
      if (ack_0 || wbeat_0 || rvalid_0 || mem_we || wbeat_1) other++;
      @(posedge clk);
      #1;
      if (saw_ack) req_1 = 1'b0;
    end
    total++;
    if (ack_c != c0 + 1) begin bad++; $display("FAIL read_ack_time: got %0d want %0d", ack_c, c0 + 1); end
    total++;
    if (rv_n != 1 || rv_c != c0 + 2) begin
      bad++;
      $display("FAIL read_rvalid: got count=%0d cycle=%0d want 1 at %0d", rv_n, rv_c, c0 + 2);
    end
    total++;
    if (other != 0) begin bad++; $display("FAIL read_other: got %0d strobes want 0", other); end
    total++;
    if (rdata_1 !== 16'h1234) begin bad++; $display("FAIL read_hold: got %h want 1234", rdata_1); end
  endtask

  task automatic test_tie();
    int g [4];
    int exp_g [4];
    int n, both;
`ifdef MM_PORT_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    preload(8'h20, 16'h2020);
    preload(8'h30, 16'h3030);
    @(posedge clk);
    #1;
    req_0 = 1'b1; we_0 = 1'b0; addr_0 = 8'h20; len_0 = 4'd0;
    req_1 = 1'b1; we_1 = 1'b0; addr_1 = 8'h30; len_1 = 4'd0;
    n = 0; both = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (ack_0 && ack_1) both++;
      if (ack_0 && n < 4) begin g[n] = 0; n++; rq0.push_back(mem[8'h20]); end
      else if (ack_1 && n < 4) begin g[n] = 1; n++; rq1.push_back(mem[8'h30]); end
      @(posedge clk);
      #1;
      if (n == 4) begin req_0 = 1'b0; req_1 = 1'b0; end
    end
    req_0 = 1'b0; req_1 = 1'b0;
    repeat (3) @(posedge clk);
    total++;
    if (n != 4 || both != 0) begin
      bad++;
      $display("FAIL tie_grants: got %0d grants (%0d double) want 4 (0)", n, both);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (g[i] != exp_g[i]) begin
        bad++;
        $display("FAIL tie_order[%0d]: got %0d want %0d", i, g[i], exp_g[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic got_ack;
    preload(8'h82, 16'hDEAD);
    wq.push_back({8'h80, 16'hB000});
    wq.push_back({8'h81, 16'hB001});
    @(posedge clk);
    #1;
    req_0 = 1'b1; we_0 = 1'b1; addr_0 = 8'h80; len_0 = 4'd7; wdata_0 = 16'hB000;
    got_ack = 1'b0;
    for (int c = 0; c < 6 && !got_ack; c++) begin
      @(negedge clk);
      if (ack_0) got_ack = 1'b1;
    end
    total++;
    if (!got_ack) begin
      bad++;
      $display("FAIL midrst_ack: got none want ack_0");
      req_0 = 1'b0;
    end else begin
      // Beat 1 runs this cycle; reset lands at the edge that would launch beat 2.
      @(posedge clk);
      #1;
      req_0 = 1'b0; wdata_0 = 16'hB001; rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      total++;
      if (mem_we !== 1'b0 || wbeat_0 !== 1'b0 || dut.state !== IDLE) begin
        bad++;
        $display("FAIL midrst_abort: got mem_we=%b wbeat_0=%b state=%0d want 0 0 IDLE",
                 mem_we, wbeat_0, dut.state);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      total++;
      if (mem[8'h82] !== 16'hDEAD || mem[8'h81] !== 16'hB001) begin
        bad++;
        $display("FAIL midrst_mem: got 81=%h 82=%h want b001 dead", mem[8'h81], mem[8'h82]);
      end
    end
    total++;
    if (wq.size() != 0) begin bad++; $display("FAIL midrst_pending: got %0d want 0", wq.size()); end
  endtask

  task automatic test_back_to_back();
    logic       ackl [32];
    logic       rvl  [32];
    logic [7:0] adl  [32];
    int n_ack, a1, a2, rvn;
    logic saw;
    for (int k = 0; k < 4; k++) begin
      preload(8'h40 + 8'(k), 16'h4000 + 16'(k * 17));
      preload(8'h50 + 8'(k), 16'h5000 + 16'(k * 29));
    end
    @(posedge clk);
    #1;
    req_1 = 1'b1; we_1 = 1'b0; addr_1 = 8'h40; len_1 = 4'd3;
    n_ack = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      ackl[i] = ack_1; rvl[i] = rvalid_1; adl[i] = mem_addr;
      saw = ack_1;
      if (ack_1) begin
        n_ack++;
        for (int k = 0; k < 4; k++)
          rq1.push_back(mem[(n_ack == 1 ? 8'h40 : 8'h50) + 8'(k)]);
      end
      @(posedge clk);
      #1;
      if (saw) begin
        if (n_ack == 1) addr_1 = 8'h50;
        else req_1 = 1'b0;
      end
    end
    a1 = -1; a2 = -1; rvn = 0;
    for (int i = 0; i < 32; i++) begin
      if (ackl[i]) begin
        if (a1 < 0) a1 = i;
        else if (a2 < 0) a2 = i;
      end
      if (rvl[i]) rvn++;
    end
    total++;
    if (a1 < 0 || a2 < 0 || a2 - a1 != 5) begin
      bad++;
      $display("FAIL b2b_gap: got acks at %0d %0d want 5 cycles apart", a1, a2);
    end else begin
      total++;
      if (rvl[a1 + 4] !== 1'b1 || ackl[a1 + 4] !== 1'b0) begin
        bad++;
        $display("FAIL b2b_gap_rvalid: got rvalid=%b ack=%b want 1 0", rvl[a1 + 4], ackl[a1 + 4]);
      end
      for (int k = 0; k < 4; k++) begin
        total++;
        if (adl[a1 + k] !== 8'h40 + 8'(k) || adl[a2 + k] !== 8'h50 + 8'(k)) begin
          bad++;
          $display("FAIL b2b_addr[%0d]: got %h %h want %h %h", k, adl[a1 + k], adl[a2 + k],
                   8'h40 + 8'(k), 8'h50 + 8'(k));
        end
      end
    end
    total++;
    if (rvn != 8) begin bad++; $display("FAIL b2b_rvalid_count: got %0d want 8", rvn); end
  endtask

  initial begin
    rst_n = 1'b0;
    req_0 = 1'b0; req_1 = 1'b0; we_0 = 1'b0; we_1 = 1'b0;
    addr_0 = '0; addr_1 = '0; len_0 = '0; len_1 = '0;
    wdata_0 = '0; wdata_1 = '0;
    test_reset();
    test_write_wrap();
    test_single_read();
    test_tie();
    test_mid_reset();
    test_back_to_back();
    repeat (3) @(posedge clk);
    total++;
    if (wq.size() != 0 || rq0.size() != 0 || rq1.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d/%0d/%0d left want 0", wq.size(), rq0.size(), rq1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mm_port_arb.md
# mm_port_arb

Arbiter and burst sequencer that shares the read/write port 0 of the 256×16 Montgomery-multiplier operand memory between two requesters. Requester 0 is the host operand loader and requester 1 is the modexp engine. Each granted request runs an auto-incrementing burst of 1–16 beats, one beat per cycle, driving the memory's address, data and write-enable. Read data, returned one cycle after address, is routed back to the burst owner.

## Interface
- AW, 8: memory address width
- DW, 16: data width
- LW, 4: burst-length field width; beats = len+1
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_0 / req_1  in  1  burst request; held until ack
- we_0 / we_1  in  1  1 = write burst, 0 = read burst
- addr_0 / addr_1  in  AW  burst start address
- len_0 / len_1  in  LW  beats minus one
- wdata_0 / wdata_1  in  DW  write word for the current beat
- ack_0 / ack_1  out  1  one-cycle pulse; burst accepted; first beat this cycle
- wbeat_0 / wbeat_1  out  1  current wdata consumed this cycle
- rdata_0 / rdata_1  out  DW  read word
- rvalid_0 / rvalid_1  out  1  rdata valid this cycle
- mem_addr  out  AW  to memory port 0 address
- mem_din  out  DW  to memory port 0 write data; wdata of owner, combinational mux
- mem_we  out  1  to memory port 0 write enable
- mem_dout  in  DW  from memory port 0 registered read data

## Operation
- States: IDLE and BUSY.
- IDLE: sample req_0/req_1 and pick a winner. On the next edge, latch owner, we, addr, len, load the beat counter, and enter BUSY.
- With no request, stay in IDLE.
- BUSY: one beat per cycle. mem_addr = base + k, wrapping mod 256 (0xFF → 0x00). mem_we = latched we.
- On a write beat, wbeat_owner = 1.
- On the last beat (k = len), the next state is IDLE.
- The ack_owner pulse coincides with beat 0. Requester fields are not re-sampled during BUSY.
- Write requesters present word 0 together with req and advance to the next word on each edge where wbeat is high.
- Reads: rvalid_owner = 1 and rdata_owner = mem_dout in the cycle after each read beat. This includes the cycle after the last beat, which may be an IDLE cycle.
- The non-owner's rvalid, wbeat and ack stay 0.
- rdata of a non-owner holds its last value.
- mem_din follows wdata of the latched owner at all times.
- In IDLE: mem_we = 0 and mem_addr holds its last value.
- Reset (rst_n low at an edge, at any point including mid-burst):
  - state = IDLE; the burst is aborted and no further beats or rvalid are issued.
  - Outputs: all ack, wbeat, rvalid, rdata, mem_addr and mem_we are 0. last_grant = 1.

## Timing
- Requests sampled in IDLE cycle t. Beats occupy cycles t+1 … t+1+len.
- ack is high in t+1.
- Read data appears in t+2 … t+2+len.
- The state is IDLE in cycle t+2+len. The earliest next burst starts at t+3+len, a fixed one-cycle gap.
- All outputs except mem_din are registered.

## Configuration
- MM_PORT_ARB_RR_EN defined: round-robin. When both request in IDLE, the requester not granted last wins. last_grant resets to 1, so requester 0 wins the first tie.
- Not defined: fixed priority. Requester 0 always wins ties, and requester 1 can starve.
- A single requester is granted immediately in either mode.

## Structure
- Package mm_port_arb_pkg:
  - state enum (IDLE, BUSY);
  - AW/DW/LW defaults;
  - owner index type.
- Sub-module mm_port_arb_pick contains the winner selection and the last_grant register, with the macro applied inside it. The top level holds the FSM, beat counter and address/data muxing.

## Test plan
- Reset: hold rst_n low 2 cycles → all outputs 0, mem_we 0. After release with no requests, stays IDLE.
- Write wrap: req_0 write, addr 0xFE, len 3, words A0..A3 → ack_0 high 1 cycle, wbeat_0 4 cycles, writes at 0xFE, 0xFF, 0x00, 0x01 in order.
- Single read: req_1 read, addr 0x10, len 0, memory preloaded 0x1234 → rvalid_1 for one cycle, 2 cycles after request sample, rdata_1 = 0x1234.
- Tie: both request 1-beat bursts continuously.
  - With MM_PORT_ARB_RR_EN, grants alternate 0, 1, 0, 1.
  - Without it, grants are 0, 0, 0, …
- Mid-burst reset: req_0 write, len 7, rst_n low during beat 2 → mem_we 0 and no wbeat on the next cycle; state IDLE; only 0x?? bursts addresses base..base+1 written.
- Back-to-back: req_1 held after a 4-beat read → exactly one cycle with mem_we 0 and no beat between the bursts; rvalid_1 for the last beat lands in that gap cycle.
